// File: rtl/seg_scan_drv.sv
// Countdown display stage: sequential binary-to-BCD conversion feeding a two-digit,
// time-multiplexed, common-anode 7-segment display with yellow-light blinking.
module seg_scan_drv #(
    parameter logic [15:0] SCAN_DIV  = 16'd50_000,
    parameter logic [24:0] BLINK_DIV = 25'd25_000_000,
    parameter logic        BLINK_EN  = 1'b1
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [6:0] val_in,
    input  logic       val_vld,
    input  logic [2:0] light_n,
    output logic [6:0] seg,
    output logic [1:0] dig_sel,
    output logic       busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CONV   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'b111_1111;
    localparam logic [6:0] SEG_DASH  = 7'b111_1110;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'b000_0001;
            4'd1:    glyph = 7'b100_1111;
            4'd2:    glyph = 7'b001_0010;
            4'd3:    glyph = 7'b000_0110;
            4'd4:    glyph = 7'b100_1100;
            4'd5:    glyph = 7'b010_0100;
            4'd6:    glyph = 7'b010_0000;
            4'd7:    glyph = 7'b000_1111;
            4'd8:    glyph = 7'b000_0000;
            4'd9:    glyph = 7'b000_0100;
            default: glyph = SEG_BLANK;
        endcase
    endfunction

    logic [1:0]  state_r;
    logic [6:0]  shift_r;
    logic [9:0]  bcd_r;
    logic [2:0]  cnt_r;
    logic        pend_r;
    logic [6:0]  pend_val_r;
    logic [6:0]  tens_r;
    logic [6:0]  ones_r;
    logic [15:0] scan_cnt_r;
    logic        digit_r;
    logic [24:0] blink_cnt_r;
    logic        phase_r;

    logic [3:0]  tens_adj_s;
    logic [3:0]  ones_adj_s;
    logic [9:0]  bcd_step_s;
    logic [6:0]  shift_step_s;
    logic [6:0]  tens_glyph_s;
    logic [6:0]  ones_glyph_s;
    logic [6:0]  start_val_s;
    logic        blank_s;

    // One double-dabble step: add 3 to each nibble >= 5, then shift left one bit
    always_comb begin
        tens_adj_s   = (bcd_r[7:4] >= 4'd5) ? (bcd_r[7:4] + 4'd3) : bcd_r[7:4];
        ones_adj_s   = (bcd_r[3:0] >= 4'd5) ? (bcd_r[3:0] + 4'd3) : bcd_r[3:0];
        bcd_step_s   = {bcd_r[8], tens_adj_s, ones_adj_s, shift_r[6]};
        shift_step_s = {shift_r[5:0], 1'b0};
        start_val_s  = val_vld ? val_in : pend_val_r;
    end

    // Commit-time glyph mapping: hundreds digit means over-range, tens blanked when zero
    always_comb begin
        tens_glyph_s = SEG_BLANK;
        ones_glyph_s = SEG_BLANK;
        if (bcd_r[9:8] != 2'd0) begin
            tens_glyph_s = SEG_DASH;
            ones_glyph_s = SEG_DASH;
        end else if (bcd_r[7:4] == 4'd0) begin
            tens_glyph_s = SEG_BLANK;
            ones_glyph_s = glyph(bcd_r[3:0]);
        end else begin
            tens_glyph_s = glyph(bcd_r[7:4]);
            ones_glyph_s = glyph(bcd_r[3:0]);
        end
    end

    // Conversion FSM with one-deep pending slot; a strobe in COMMIT beats the pending value
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r    <= ST_IDLE;
            shift_r    <= 7'd0;
            bcd_r      <= 10'd0;
            cnt_r      <= 3'd0;
            pend_r     <= 1'b0;
            pend_val_r <= 7'd0;
            tens_r     <= SEG_BLANK;
            ones_r     <= SEG_BLANK;
            busy       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (val_vld) begin
                        shift_r <= val_in;
                        bcd_r   <= 10'd0;
                        cnt_r   <= 3'd7;
                        busy    <= 1'b1;
                        state_r <= ST_CONV;
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                ST_CONV: begin
                    bcd_r   <= bcd_step_s;
                    shift_r <= shift_step_s;
                    cnt_r   <= cnt_r - 3'd1;
                    state_r <= (cnt_r == 3'd1) ? ST_COMMIT : ST_CONV;
                    if (val_vld) begin
                        pend_r     <= 1'b1;
                        pend_val_r <= val_in;
                    end
                end
                ST_COMMIT: begin
                    tens_r <= tens_glyph_s;
                    ones_r <= ones_glyph_s;
                    if (val_vld || pend_r) begin
                        shift_r <= start_val_s;
                        bcd_r   <= 10'd0;
                        cnt_r   <= 3'd7;
                        pend_r  <= 1'b0;
                        busy    <= 1'b1;
                        state_r <= ST_CONV;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    pend_r  <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Free-running scan and blink timebases
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            scan_cnt_r  <= 16'd0;
            digit_r     <= 1'b0;
            blink_cnt_r <= 25'd0;
            phase_r     <= 1'b0;
        end else begin
            if (scan_cnt_r == (SCAN_DIV - 16'd1)) begin
                scan_cnt_r <= 16'd0;
                digit_r    <= ~digit_r;
            end else begin
                scan_cnt_r <= scan_cnt_r + 16'd1;
            end
            if (blink_cnt_r == (BLINK_DIV - 25'd1)) begin
                blink_cnt_r <= 25'd0;
                phase_r     <= ~phase_r;
            end else begin
                blink_cnt_r <= blink_cnt_r + 25'd1;
            end
        end
    end

    // Blank segments during the off phase while yellow is lit
    always_comb begin
        blank_s = BLINK_EN && (light_n == 3'b011) && phase_r;
    end

    // Registered display drive
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            seg     <= SEG_BLANK;
            dig_sel <= 2'b11;
        end else begin
            seg     <= blank_s ? SEG_BLANK : (digit_r ? tens_r : ones_r);
            dig_sel <= digit_r ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: tb/tb_seg_scan_drv.sv
// Bench for seg_scan_drv: directed stimulus, a cycle-level reference model compared every
// cycle, plus hand-computed literal expectations.
module tb_seg_scan_drv;

    localparam int SD = 4;
    localparam int BD = 16;
    localparam logic [6:0] GLYPH [10] = '{7'b000_0001, 7'b100_1111, 7'b001_0010, 7'b000_0110,
                                          7'b100_1100, 7'b010_0100, 7'b010_0000, 7'b000_1111,
                                          7'b000_0000, 7'b000_0100};

    logic       sys_clk;
    logic       sys_rst_n;
    logic [6:0] val_in;
    logic       val_vld;
    logic [2:0] light_n;
    logic [6:0] seg;
    logic [1:0] dig_sel;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int   m_n = 0, m_ce = 0, m_cv = 0, m_pval = 0, m_disp = 0;
    bit   m_act = 1'b0, m_pv = 1'b0, m_ok = 1'b0;
    logic [6:0] exp_seg = 7'h7F;
    logic [1:0] exp_dig = 2'b11;
    logic       exp_busy = 1'b0;
    int   t_e, t_dig, t_ph, t_ce, t_cv, t_pval, t_disp;
    bit   t_act, t_pv, t_ok;

    seg_scan_drv #(.SCAN_DIV(16'd4), .BLINK_DIV(25'd16), .BLINK_EN(1'b1)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .val_in(val_in), .val_vld(val_vld),
        .light_n(light_n), .seg(seg), .dig_sel(dig_sel), .busy(busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic logic [6:0] disp_seg(input bit ok, input int v, input int dig);
        if (!ok) return 7'h7F;
        if (v >= 100) return 7'h7E;
        if (dig == 0) return GLYPH[v % 10];
        if (v < 10) return 7'h7F;
        return GLYPH[v / 10];
    endfunction

    // Model: commit edge = strobe edge + 8; strobes while active go to a last-wins pending slot
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_n <= 0; m_act <= 1'b0; m_pv <= 1'b0; m_ok <= 1'b0;
            exp_seg <= 7'h7F; exp_dig <= 2'b11; exp_busy <= 1'b0;
        end else begin
            t_e = m_n + 1;
            t_dig = ((t_e - 1) / SD) % 2;
            t_ph  = ((t_e - 1) / BD) % 2;
            t_act = m_act; t_ce = m_ce; t_cv = m_cv; t_pv = m_pv; t_pval = m_pval;
            t_ok = m_ok; t_disp = m_disp;
            if (val_vld && t_act) begin
                t_pv = 1'b1; t_pval = int'(val_in);
            end
            if (t_act && t_e == t_ce) begin
                t_ok = 1'b1; t_disp = t_cv;
                if (t_pv) begin
                    t_cv = t_pval; t_ce = t_e + 8; t_pv = 1'b0;
                end else begin
                    t_act = 1'b0;
                end
            end else if (!t_act && val_vld) begin
                t_act = 1'b1; t_cv = int'(val_in); t_ce = t_e + 8;
            end
            exp_dig  <= (t_dig == 1) ? 2'b01 : 2'b10;
            exp_seg  <= (t_ph == 1 && light_n == 3'b011) ? 7'h7F : disp_seg(m_ok, m_disp, t_dig);
            exp_busy <= t_act;
            m_n <= t_e; m_act <= t_act; m_ce <= t_ce; m_cv <= t_cv; m_pv <= t_pv;
            m_pval <= t_pval; m_ok <= t_ok; m_disp <= t_disp;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic strobe(input logic [6:0] v);
        val_in = v; val_vld = 1'b1;
        tick();
        val_vld = 1'b0;
    endtask

    task automatic check_slot(input string nm, input logic [1:0] sel, input logic [6:0] want);
        int k = 0;
        while (dig_sel !== sel && k < 16) begin
            tick();
            k++;
        end
        if (k >= 16) begin
            n_checks++; n_errors++;
            $display("FAIL %s: dig_sel never reached %b (last %b)", nm, sel, dig_sel);
        end else begin
            chk(nm, 32'(seg), 32'(want));
        end
    endtask

    initial begin
        sys_rst_n = 1'b1; val_in = 7'd0; val_vld = 1'b0; light_n = 3'b110;
        #2 sys_rst_n = 1'b0;
        fork
            begin : cmp
                forever begin
                    @(negedge sys_clk);
                    chk("model_seg", 32'(seg), 32'(exp_seg));
                    chk("model_dig_sel", 32'(dig_sel), 32'(exp_dig));
                    chk("model_busy", 32'(busy), 32'(exp_busy));
                end
            end
            begin : seq
                int hits, ob, os, tc, tbad;
                repeat (3) tick();
                chk("rst_seg", 32'(seg), 32'h7F);
                chk("rst_dig_sel", 32'(dig_sel), 32'h3);
                chk("rst_busy", 32'(busy), 32'h0);
                sys_rst_n = 1'b1;

                // 10: busy cycles 1..8, commit at 9
                strobe(7'd10);
                for (int c = 1; c <= 9; c++) begin
                    chk("busy_10", 32'(busy), 32'(c <= 8));
                    if (c < 9) tick();
                end
                tick();
                check_slot("v10_ones", 2'b10, 7'b000_0001);
                check_slot("v10_tens", 2'b01, 7'b100_1111);

                strobe(7'd7); repeat (10) tick();
                check_slot("v7_ones", 2'b10, 7'b000_1111);
                check_slot("v7_tens", 2'b01, 7'b111_1111);

                strobe(7'd99); repeat (10) tick();
                check_slot("v99_ones", 2'b10, 7'b000_0100);
                check_slot("v99_tens", 2'b01, 7'b000_0100);
                strobe(7'd100); repeat (10) tick();
                check_slot("v100_ones", 2'b10, 7'b111_1110);
                check_slot("v100_tens", 2'b01, 7'b111_1110);

                // back-to-back: 5 at cycle 0, 3 at cycle 3, 2 at cycle 5
                strobe(7'd5);
                hits = 0;
                for (int c = 1; c <= 17; c++) begin
                    chk("busy_b2b", 32'(busy), 32'(c <= 16));
                    if (c >= 10 && dig_sel == 2'b10) begin
                        chk("b2b_five", 32'(seg), 32'(7'b010_0100));
                        hits++;
                    end
                    val_vld = (c == 3 || c == 5);
                    val_in  = (c == 3) ? 7'd3 : 7'd2;
                    if (c < 17) tick();
                end
                val_vld = 1'b0;
                chk("b2b_five_seen", 32'(hits > 0), 32'h1);
                tick();
                check_slot("b2b_two_ones", 2'b10, 7'b001_0010);
                check_slot("b2b_two_tens", 2'b01, 7'b111_1111);

                // blink with value 3
                strobe(7'd3); repeat (10) tick();
                light_n = 3'b011; tick(); tick();
                ob = 0; os = 0; tc = 0; tbad = 0;
                for (int i = 0; i < 64; i++) begin
                    if (dig_sel == 2'b10) begin
                        if (seg == 7'h7F) ob++;
                        else if (seg == 7'b000_0110) os++;
                    end else if (dig_sel == 2'b01) begin
                        tc++;
                        if (seg != 7'h7F) tbad++;
                    end
                    tick();
                end
                chk("blink_ones_blank", ob, 16);
                chk("blink_ones_shown", os, 16);
                chk("blink_tens_slots", tc, 32);
                chk("blink_tens_bad", tbad, 0);
                light_n = 3'b110; tick();
                ob = 0; os = 0;
                for (int i = 0; i < 32; i++) begin
                    if (dig_sel == 2'b10 && seg == 7'h7F) ob++;
                    if (dig_sel == 2'b10 && seg == 7'b000_0110) os++;
                    tick();
                end
                chk("red_ones_blank", ob, 0);
                chk("red_ones_shown", os, 16);

                // reset at cycle 4 of a conversion
                strobe(7'd42); repeat (3) tick();
                #1 sys_rst_n = 1'b0;
                #1;
                chk("arst_seg", 32'(seg), 32'h7F);
                chk("arst_dig_sel", 32'(dig_sel), 32'h3);
                chk("arst_busy", 32'(busy), 32'h0);
                tick(); tick();
                sys_rst_n = 1'b1;
                ob = 0; tbad = 0;
                for (int i = 0; i < 20; i++) begin
                    if (seg != 7'h7F) ob++;
                    if (busy) tbad++;
                    tick();
                end
                chk("post_rst_lit", ob, 0);
                chk("post_rst_busy", tbad, 0);
                strobe(7'd42); repeat (10) tick();
                check_slot("v42_ones", 2'b10, 7'b001_0010);
                check_slot("v42_tens", 2'b01, 7'b100_1100);
                tick();
            end
        join_any
        disable fork;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
